// File: rtl/pkg_ili9341.sv
// Shared definitions for the ILI9341 SPI byte transmitter.
// Provides the FSM state encoding, pin-level constants and the default
// SCK half-period divider.
package pkg_ili9341;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCK_HI,
    SCK_LO,
    DONE
  } spi_state_t;

  localparam logic LOW     = 1'b0;
  localparam logic HIGH    = 1'b1;
  // Value shifted into the serializer behind the last bit; MOSI level when idle.
  localparam logic NO_DATA = 1'b0;

  localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/spi_half_period_cnt.sv
// Reloadable down-counter that paces the SPI phases.
// While enabled it counts CLK_DIV-1 .. 0 and raises tick_c on the terminal
// count (once every CLK_DIV cycles); while disabled it sits at the reload value.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   en        count enable (phase in progress)
//   tick_c    combinational terminal-count strobe
module spi_half_period_cnt
  import pkg_ili9341::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick_c = en && (cnt == '0);

  // Reload on terminal count or when idle so every phase gets a full CLK_DIV.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= RELOAD;
    end else if (!en || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ili9341_spi_tx.sv
// Byte-level SPI (mode 0, MSB first) transmitter for the ILI9341 4-wire
// serial interface. Accepts one byte per i_send/o_byte_sent handshake along
// with its D/C and CS levels and serializes it on SCK/MOSI.
// Optional macro ILI9341_MISO_CAPTURE_EN adds MISO capture (i_miso, o_rx_data).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_send       transfer request (level, held until o_byte_sent)
//   i_data       byte to send
//   i_dc, i_cs   D/C and CS levels for this byte
//   i_miso       (macro) serial data from the panel
//   o_rx_data    (macro) byte captured from MISO, updated in the DONE cycle
//   o_byte_sent  one-cycle completion strobe
//   o_busy       high from accept through DONE
//   o_sck, o_mosi, o_dc, o_cs  panel pins (all registered)
module ili9341_spi_tx
  import pkg_ili9341::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_send,
  input  logic [DW-1:0] i_data,
  input  logic          i_dc,
  input  logic          i_cs,
`ifdef ILI9341_MISO_CAPTURE_EN
  input  logic          i_miso,
  output logic [DW-1:0] o_rx_data,
`endif
  output logic          o_byte_sent,
  output logic          o_busy,
  output logic          o_sck,
  output logic          o_mosi,
  output logic          o_dc,
  output logic          o_cs
);

  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  spi_state_t    state;
  logic [DW-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic          div_en;
  logic          tick;

  // Divider runs only while a phase is timing out.
  assign div_en = (state == LOAD) || (state == SCK_HI) || (state == SCK_LO);

  spi_half_period_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (div_en),
    .tick_c (tick)
  );

  // MOSI is the serializer MSB; the register is zero in idle and after the
  // last shift, so the pin idles low without extra logic.
  assign o_mosi = shreg[DW-1];

  // Transfer FSM with registered pin outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= BIT_LAST;
      o_sck       <= LOW;
      o_cs        <= HIGH;
      o_dc        <= HIGH;
      o_byte_sent <= LOW;
      o_busy      <= LOW;
    end else begin
      o_byte_sent <= LOW;
      unique case (state)
        IDLE: begin
          if (i_send) begin
            shreg   <= i_data;
            bit_cnt <= BIT_LAST;
            o_cs    <= i_cs;
            o_dc    <= i_dc;
            o_busy  <= HIGH;
            o_sck   <= LOW;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (tick) begin
            o_sck <= HIGH;
            state <= SCK_HI;
          end
        end
        SCK_HI: begin
          // Falling edge: present the next lower bit for the following rise.
          if (tick) begin
            o_sck <= LOW;
            shreg <= {shreg[DW-2:0], NO_DATA};
            state <= SCK_LO;
          end
        end
        SCK_LO: begin
          if (tick) begin
            if (bit_cnt == '0) begin
              o_byte_sent <= HIGH;
              state       <= DONE;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
              o_sck   <= HIGH;
              state   <= SCK_HI;
            end
          end
        end
        DONE: begin
          o_busy <= LOW;
          o_cs   <= HIGH;
          o_dc   <= HIGH;
          o_sck  <= LOW;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ILI9341_MISO_CAPTURE_EN
  logic [DW-1:0] rx_shift;

  // MISO sampled on the last clk of each high phase; published on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift  <= '0;
      o_rx_data <= '0;
    end else begin
      if ((state == SCK_HI) && tick) begin
        rx_shift <= {rx_shift[DW-2:0], i_miso};
      end
      if ((state == SCK_LO) && tick && (bit_cnt == '0)) begin
        o_rx_data <= rx_shift;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Bench for ili9341_spi_tx: one instance with CLK_DIV=4 (index 0) and one
// with CLK_DIV=1 (index 1). A per-cycle model predicts every pin from the
// offset since the accept edge.
module tb_ili9341_spi_tx;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]        send   = '0;
  logic [1:0][DW-1:0] data  = '0;
  logic [1:0]        dc_in  = '1;
  logic [1:0]        cs_in  = '1;
  logic [1:0]        sent, busy, sck, mosi, dc_out, cs_out;

`ifdef ILI9341_MISO_CAPTURE_EN
  logic          miso0;
  logic [DW-1:0] rx0, rx1;
`endif

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // Inputs as seen at the most recent rising edge.
  bit                 s_rst = 1'b0;
  logic [1:0]         s_send = '0;
  logic [1:0][DW-1:0] s_data = '0;
  logic [1:0]         s_dc = '0, s_cs = '0;

  // Model state per instance.
  bit [1:0]      active = '0;
  int            acc [2] = '{0, 0};
  logic [DW-1:0] lat_data [2];
  logic          lat_dc [2], lat_cs [2];
  int            rises [2] = '{0, 0};
  logic [DW-1:0] rx_bits [2];
  int            pulses [2] = '{0, 0};
  int            sent_k [2] = '{0, 0};
  int            last_rise [2] = '{0, 0};
  int            last_period [2] = '{0, 0};
  logic [1:0]    prev_sck = '0;

  always #5 clk = ~clk;

  ili9341_spi_tx #(.DW(DW), .CLK_DIV(4)) u_d4 (
    .clk         (clk),
    .rst         (rst),
    .i_send      (send[0]),
    .i_data      (data[0]),
    .i_dc        (dc_in[0]),
    .i_cs        (cs_in[0]),
`ifdef ILI9341_MISO_CAPTURE_EN
    .i_miso      (miso0),
    .o_rx_data   (rx0),
`endif
    .o_byte_sent (sent[0]),
    .o_busy      (busy[0]),
    .o_sck       (sck[0]),
    .o_mosi      (mosi[0]),
    .o_dc        (dc_out[0]),
    .o_cs        (cs_out[0])
  );

  ili9341_spi_tx #(.DW(DW), .CLK_DIV(1)) u_d1 (
    .clk         (clk),
    .rst         (rst),
    .i_send      (send[1]),
    .i_data      (data[1]),
    .i_dc        (dc_in[1]),
    .i_cs        (cs_in[1]),
`ifdef ILI9341_MISO_CAPTURE_EN
    .i_miso      (1'b0),
    .o_rx_data   (rx1),
`endif
    .o_byte_sent (sent[1]),
    .o_busy      (busy[1]),
    .o_sck       (sck[1]),
    .o_mosi      (mosi[1]),
    .o_dc        (dc_out[1]),
    .o_cs        (cs_out[1])
  );

`ifdef ILI9341_MISO_CAPTURE_EN
  // Panel model: bit r of 0x5C is on MISO during the high phase of rise r.
  function automatic logic miso_pat_bit(int r);
    logic [7:0] pat;
    pat = 8'h5C;
    if (r < 1) return pat[7];
    if (r > 8) return 1'b0;
    return pat[8-r];
  endfunction
  assign miso0 = miso_pat_bit(rises[0]);
`endif

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Expected {sck, mosi, cs, dc, busy, sent} at offset k (k=1 is the first
  // cycle after the accept edge). care=0 when MOSI is unspecified.
  function automatic logic [5:0] model_vec(int k, int d, logic [7:0] b,
                                           logic dcv, logic csv, output bit care);
    int m, bi, ph;
    logic nb;
    care = 1'b1;
    if (k <= d) return {1'b0, b[7], csv, dcv, 1'b1, 1'b0};
    if (k == 1 + 17 * d) begin
      care = 1'b0;
      return {1'b0, 1'b0, csv, dcv, 1'b1, 1'b1};
    end
    m  = k - 1 - d;
    bi = m / (2 * d);
    ph = m % (2 * d);
    if (ph < d) return {1'b1, b[7-bi], csv, dcv, 1'b1, 1'b0};
    nb = 1'b0;
    if (bi < 7) nb = b[6-bi];
    else care = 1'b0;
    return {1'b0, nb, csv, dcv, 1'b1, 1'b0};
  endfunction

  always @(posedge clk) begin
    edge_n++;
    s_rst  = rst;
    s_send = send;
    s_data = data;
    s_dc   = dc_in;
    s_cs   = cs_in;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp_proc
    logic [5:0] act, expv, mask;
    bit care;
    int k, d;
    for (int i = 0; i < 2; i++) begin
      d = div_of(i);
      if (!rst) begin
        active[i] = 1'b0;
      end else if (s_rst && s_send[i] &&
                   (!active[i] || (edge_n - acc[i] > 1 + 17 * d))) begin
        active[i]   = 1'b1;
        acc[i]      = edge_n;
        lat_data[i] = s_data[i];
        lat_dc[i]   = s_dc[i];
        lat_cs[i]   = s_cs[i];
        rises[i]    = 0;
        rx_bits[i]  = '0;
      end
      k    = edge_n - acc[i] + 1;
      mask = '1;
      care = 1'b1;
      if (rst && active[i] && (k <= 1 + 17 * d)) begin
        expv = model_vec(k, d, lat_data[i], lat_dc[i], lat_cs[i], care);
        if (!care) mask[4] = 1'b0;
      end else begin
        expv = 6'b001100;
      end
      act = {sck[i], mosi[i], cs_out[i], dc_out[i], busy[i], sent[i]};
      tests++;
      if ((act & mask) !== (expv & mask)) begin
        fails++;
        $display("FAIL wire_dut%0d cycle=%0d k=%0d act(sck,mosi,cs,dc,busy,sent)=%b exp=%b",
                 i, edge_n, k, act & mask, expv & mask);
      end
      if (sck[i] && !prev_sck[i]) begin
        rises[i]++;
        rx_bits[i] = {rx_bits[i][6:0], mosi[i]};
        if (rises[i] > 1) last_period[i] = edge_n - last_rise[i];
        last_rise[i] = edge_n;
      end
      prev_sck[i] = sck[i];
      if (sent[i]) begin
        pulses[i]++;
        sent_k[i] = k;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp_v);
    end
  endtask

  task automatic start(input int i, input logic [7:0] b, input logic dcv, input logic csv);
    @(negedge clk);
    #1;
    send[i]  = 1'b1;
    data[i]  = b;
    dc_in[i] = dcv;
    cs_in[i] = csv;
  endtask

  task automatic wait_sent(input int i, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      #1;
      if (sent[i]) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s act=no o_byte_sent exp=pulse within 400 cycles", name);
    end
  endtask

  task automatic wait_rises(input int i, input int n, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      #1;
      if (rises[i] >= n) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s act=%0d rises exp=%0d within 400 cycles", name, rises[i], n);
    end
  endtask

  initial begin
    int p, a1;
    logic [7:0] b1;

    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_pins_dut%0d", i),
          32'({sck[i], mosi[i], cs_out[i], dc_out[i], busy[i], sent[i]}), 32'h0C);
    end
`ifdef ILI9341_MISO_CAPTURE_EN
    chk("reset_rx_data", 32'(rx0), 32'h0);
`endif
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;

    // Command byte 0x2A, DC=0, CS=0 at CLK_DIV=4.
    p = pulses[0];
    start(0, 8'h2A, 1'b0, 1'b0);
    wait_sent(0, "cmd_sent");
    send[0] = 1'b0;
    chk("cmd_latency", 32'(sent_k[0]), 32'd69);
    chk("cmd_bits", 32'(rx_bits[0]), 32'h2A);
    chk("cmd_rises", 32'(rises[0]), 32'd8);
    chk("cmd_sck_period", 32'(last_period[0]), 32'd8);
    @(negedge clk);
    #1;
    chk("cmd_cs_release_n70", 32'(cs_out[0]), 32'd1);
    chk("cmd_busy_release", 32'(busy[0]), 32'd0);
    chk("cmd_pulses", 32'(pulses[0] - p), 32'd1);

    // Minimum divider, 0xFF as data.
    start(1, 8'hFF, 1'b1, 1'b0);
    wait_sent(1, "div1_sent");
    send[1] = 1'b0;
    chk("div1_latency", 32'(sent_k[1]), 32'd18);
    chk("div1_bits", 32'(rx_bits[1]), 32'hFF);
    chk("div1_rises", 32'(rises[1]), 32'd8);
    chk("div1_sck_period", 32'(last_period[1]), 32'd2);

    // Back-to-back: sequencer keeps i_send high and swaps the byte on the pulse.
    p = pulses[0];
    start(0, 8'h11, 1'b0, 1'b0);
    wait_sent(0, "b2b_first_sent");
    b1 = rx_bits[0];
    a1 = acc[0];
    data[0]  = 8'h29;
    dc_in[0] = 1'b1;
    wait_sent(0, "b2b_second_sent");
    send[0] = 1'b0;
    chk("b2b_first_bits", 32'(b1), 32'h11);
    chk("b2b_accept_gap", 32'(acc[0] - a1), 32'd70);
    chk("b2b_second_bits", 32'(rx_bits[0]), 32'h29);
    chk("b2b_second_latency", 32'(sent_k[0]), 32'd69);
    chk("b2b_pulses", 32'(pulses[0] - p), 32'd2);

    // Inputs changed after accept must not reach the wire.
    start(0, 8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    data[0]  = 8'h00;
    dc_in[0] = 1'b0;
    cs_in[0] = 1'b1;
    wait_sent(0, "late_sent");
    send[0] = 1'b0;
    chk("late_bits", 32'(rx_bits[0]), 32'hA5);
    chk("late_dc_held", 32'(dc_out[0]), 32'd1);
    chk("late_cs_held", 32'(cs_out[0]), 32'd0);

    // Reset during bit 4 aborts the byte immediately.
    p = pulses[0];
    start(0, 8'h3C, 1'b1, 1'b0);
    wait_rises(0, 5, "rst_wait_bit4");
    @(posedge clk);
    #2;
    rst     = 1'b0;
    send[0] = 1'b0;
    #1;
    chk("rst_sck", 32'(sck[0]), 32'd0);
    chk("rst_cs", 32'(cs_out[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_sent", 32'(sent[0]), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    chk("rst_no_pulse", 32'(pulses[0] - p), 32'd0);
    start(0, 8'h96, 1'b1, 1'b0);
    wait_sent(0, "post_rst_sent");
    send[0] = 1'b0;
    chk("post_rst_latency", 32'(sent_k[0]), 32'd69);
    chk("post_rst_bits", 32'(rx_bits[0]), 32'h96);
    chk("post_rst_pulses", 32'(pulses[0] - p), 32'd1);

`ifdef ILI9341_MISO_CAPTURE_EN
    // MISO capture of 0x5C, held through idle.
    start(0, 8'h00, 1'b1, 1'b0);
    wait_sent(0, "miso_sent");
    send[0] = 1'b0;
    chk("miso_rx_done", 32'(rx0), 32'h5C);
    repeat (5) @(negedge clk);
    #1;
    chk("miso_rx_held", 32'(rx0), 32'h5C);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
